n101_deglitch_filter: RTL and testbench
=======================================

N101_DEGLITCH_FILTER -- requirements
Module: n101_deglitch_filter

Interface
REQ-001 Parameter CH, default 8: number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth per channel (2..4).
REQ-003 Parameter CNT_W, default 4: stability counter width; maximum threshold is 2^CNT_W-1.
REQ-004 clock  input  1  sole clock; all flops on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 io_d  input  CH  raw asynchronous pad inputs, one bit per channel.
REQ-007 io_en  input  1  filter enable; low freezes the filtered outputs.
REQ-008 io_thresh  input  CNT_W  number of consecutive stable cycles needed to accept a change (shared by all channels).
REQ-009 io_q  output  CH  deglitched, synchronized channel levels.
REQ-010 io_rise  output  CH  one-cycle pulse when the io_q bit rises.
REQ-011 io_fall  output  CH  one-cycle pulse when the io_q bit falls.
REQ-012 io_ie  input  CH  per-channel interrupt enable.
REQ-013 io_clr  input  CH  per-channel pending-clear strobe.
REQ-014 io_pend  output  CH  sticky per-channel edge-pending flags.
REQ-015 io_irq  output  1  OR-reduction of io_pend.

Function
REQ-016 Each channel SHALL pass io_d through a SYNC_STAGES-deep flop chain; the last stage is "s".
REQ-017 The synchronizer chain SHALL run regardless of io_en.
REQ-018 Each channel counter cnt SHALL clear on any cycle where s == io_q or io_en == 0.
REQ-019 Otherwise, cnt SHALL increment, saturating at 2^CNT_W-1 and never wrapping.
REQ-020 When s != io_q, io_en == 1 and cnt+1 >= eff_thresh, io_q SHALL take s on that edge and cnt SHALL clear; eff_thresh = max(io_thresh, 1).
REQ-021 Latency: a stable io_d change SHALL appear on io_q at rising edge SYNC_STAGES+eff_thresh after the change, counting the first capturing edge as 1.
REQ-022 A pulse on s shorter than eff_thresh cycles SHALL leave io_q unchanged and clear cnt.
REQ-023 If io_thresh changes mid-count, the comparison SHALL use the new value from that cycle; if cnt+1 already meets it, io_q SHALL update immediately.
REQ-024 io_rise/io_fall SHALL be registered and SHALL assert exactly in the cycle after the io_q transition, for one cycle.
REQ-025 io_pend[i] SHALL set when io_ie[i]=1 in a cycle where io_rise[i] or io_fall[i] is high.
REQ-026 io_pend[i] SHALL clear on io_clr[i]=1; simultaneous set and clear SHALL leave it set.
REQ-027 io_irq SHALL be the combinational OR of io_pend.
REQ-028 Channels SHALL be fully independent; no cross-channel interaction.

Reset
REQ-029 On reset assertion, all synchronizer flops, cnt, io_q, io_rise, io_fall and io_pend SHALL go to 0 immediately.
REQ-030 After reset release, io_q SHALL follow REQ-020 from the reset value 0, so an input held high reaches io_q after SYNC_STAGES+eff_thresh edges.
REQ-031 Reset asserted mid-count SHALL abort the count with no io_q change and no edge pulse.

Configuration
REQ-032 Macro N101_DEGLITCH_EDGE_IRQ_EN, when defined, SHALL compile in the edge-pulse, pending and irq logic of REQ-024..REQ-027.
REQ-033 When N101_DEGLITCH_EDGE_IRQ_EN is undefined, io_rise, io_fall, io_pend and io_irq SHALL be tied to 0, io_ie/io_clr SHALL be ignored, and the port list SHALL be unchanged.

Verification
REQ-034 Defaults, io_thresh=3, io_en=1: io_d[0] 0->1 held -> io_q[0] rises on edge 5; io_rise[0] pulses on edge 6; other channels stay 0.
REQ-035 io_thresh=4: a 3-cycle high glitch on io_d[2] -> io_q[2] stays 0 and io_rise[2] never pulses; a 4-cycle pulse -> io_q[2] high for exactly 4 cycles.
REQ-036 io_thresh=0 -> behaves as threshold 1: io_q follows io_d with 3-edge latency.
REQ-037 io_ie[1]=1, io_q[1] falls, and io_clr[1] is asserted in the same cycle as io_fall[1] -> io_pend[1] stays set and io_irq=1; io_clr[1] next cycle -> io_pend[1]=0 and io_irq=0.
REQ-038 io_en=0 while io_d toggles -> io_q frozen and no pulses; io_en=1 with io_d stable high -> io_q rises eff_thresh edges later.
REQ-039 reset pulsed mid-count with io_d[0]=1 -> all outputs 0 at once; after release io_q[0] rises after SYNC_STAGES+eff_thresh edges. Macro undefined -> io_irq stays 0 throughout.

Source files
------------

// File: rtl/n101_deglitch_filter.sv
// n101_deglitch_filter: multi-channel pad synchronizer and deglitcher.
// Each channel runs io_d through a flop chain, then requires the synchronized
// level to differ from io_q for eff_thresh consecutive enabled cycles before
// io_q follows it. Edge pulses, sticky pending flags and the irq line are
// compiled in only when N101_DEGLITCH_EDGE_IRQ_EN is defined; otherwise those
// outputs are tied low and io_ie/io_clr are ignored.
module n101_deglitch_filter #(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CH-1:0]    io_d,
    input  logic             io_en,
    input  logic [CNT_W-1:0] io_thresh,
    output logic [CH-1:0]    io_q,
    output logic [CH-1:0]    io_rise,
    output logic [CH-1:0]    io_fall,
    input  logic [CH-1:0]    io_ie,
    input  logic [CH-1:0]    io_clr,
    output logic [CH-1:0]    io_pend,
    output logic             io_irq
);

    // Index 0 captures the pad; index SYNC_STAGES-1 is the settled level.
    logic [SYNC_STAGES-1:0][CH-1:0] sync_p;
    logic [CH-1:0]                  s;
    logic [CH-1:0]                  q_r;
    logic [CH-1:0]                  q_next;
    logic [CH-1:0][CNT_W-1:0]       cnt;
    logic [CH-1:0][CNT_W-1:0]       cnt_next;
    logic [CNT_W-1:0]               eff_thresh;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign s          = sync_p[SYNC_STAGES-1];
    // A zero threshold would mean "accept without seeing the level", so treat it as 1.
    assign eff_thresh = (io_thresh == '0) ? CNT_W'(1) : io_thresh;
    assign io_q       = q_r;

    // Synchronizer chain: always shifting, independent of the enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], io_d};
        end
    end

    // Per-channel stability count and accept decision.
    always_comb begin
        logic [CNT_W:0] cnt_plus;
        cnt_plus = '0;
        q_next   = q_r;
        cnt_next = cnt;
        for (int i = 0; i < CH; i++) begin
            // One extra bit so cnt+1 is compared exactly even at the top of the range.
            cnt_plus = {1'b0, cnt[i]} + (CNT_W+1)'(1);
            if (!io_en || (s[i] == q_r[i])) begin
                cnt_next[i] = '0;
            end else if (cnt_plus >= {1'b0, eff_thresh}) begin
                q_next[i]   = s[i];
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = sat_inc(cnt[i]);
            end
        end
    end

    // Filtered level and counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_r <= '0;
            cnt <= '0;
        end else begin
            q_r <= q_next;
            cnt <= cnt_next;
        end
    end

`ifdef N101_DEGLITCH_EDGE_IRQ_EN
    logic [CH-1:0] q_d;
    logic [CH-1:0] rise_r;
    logic [CH-1:0] fall_r;
    logic [CH-1:0] pend_r;

    // Edge pulses one cycle after io_q moves; pending set beats clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_d    <= '0;
            rise_r <= '0;
            fall_r <= '0;
            pend_r <= '0;
        end else begin
            q_d    <= q_r;
            rise_r <= q_r & ~q_d;
            fall_r <= ~q_r & q_d;
            pend_r <= (pend_r & ~io_clr) | (io_ie & (rise_r | fall_r));
        end
    end

    assign io_rise = rise_r;
    assign io_fall = fall_r;
    assign io_pend = pend_r;
    assign io_irq  = |pend_r;
`else
    logic unused_edge_inputs;
    assign unused_edge_inputs = ^{io_ie, io_clr};
    assign io_rise = '0;
    assign io_fall = '0;
    assign io_pend = '0;
    assign io_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_n101_deglitch_filter.sv
// Testbench for n101_deglitch_filter (default parameters). Expectations come
// from a delay-line plus run-length model of the filtering rules; edge/pending
// expectations follow N101_DEGLITCH_EDGE_IRQ_EN the same way the DUT build does.
module tb_n101_deglitch_filter;
    localparam int CH = 8;
    localparam int SS = 2;
    localparam int CW = 4;
    localparam int VW = 4*CH + 1;
`ifdef N101_DEGLITCH_EDGE_IRQ_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [CH-1:0] io_d, io_q, io_rise, io_fall, io_ie, io_clr, io_pend;
    logic          io_en, io_irq;
    logic [CW-1:0] io_thresh;
    logic [VW-1:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [CH-1:0] m_q, m_qp, m_rise, m_fall, m_pend;
    int            m_run [CH];
    logic [CH-1:0] m_hist [$];

    n101_deglitch_filter #(.CH(CH), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .io_d(io_d), .io_en(io_en),
        .io_thresh(io_thresh), .io_q(io_q), .io_rise(io_rise),
        .io_fall(io_fall), .io_ie(io_ie), .io_clr(io_clr),
        .io_pend(io_pend), .io_irq(io_irq)
    );

    always #5 clock = ~clock;
    assign dut_vec = {io_q, io_rise, io_fall, io_pend, io_irq};

    function automatic logic [VW-1:0] exp_vec();
        return {m_q, m_rise, m_fall, m_pend, |m_pend};
    endfunction

    task automatic model_reset();
        m_q = '0; m_qp = '0; m_rise = '0; m_fall = '0; m_pend = '0;
        for (int i = 0; i < CH; i++) m_run[i] = 0;
        m_hist = {};
        for (int k = 0; k < SS; k++) m_hist.push_back('0);
    endtask

    // One rising edge of the reference: s is the pad value from SS edges ago,
    // a channel flips once it has seen eff consecutive enabled mismatches.
    task automatic model_edge();
        logic [CH-1:0] s, nr, nf;
        int eff;
        if (reset) begin
            model_reset();
            return;
        end
        s   = m_hist[0];
        eff = (io_thresh == 0) ? 1 : int'(io_thresh);
        nr  = m_q & ~m_qp;
        nf  = ~m_q & m_qp;
        if (EDGE_EN) begin
            m_pend = (m_pend & ~io_clr) | (io_ie & (m_rise | m_fall));
            m_rise = nr;
            m_fall = nf;
        end
        m_qp = m_q;
        for (int i = 0; i < CH; i++) begin
            if (!io_en || s[i] == m_q[i]) m_run[i] = 0;
            else if (m_run[i] + 1 >= eff) begin
                m_q[i]   = s[i];
                m_run[i] = 0;
            end else m_run[i]++;
        end
        void'(m_hist.pop_front());
        m_hist.push_back(io_d);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; io_d = '0; io_en = 1'b1; io_thresh = 4'd3;
        io_ie = '0; io_clr = '0;
        model_reset();
        #3;
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL reset_state got %h exp 0", dut_vec);
        end
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_basic_latency();
        io_thresh = 4'd3; io_en = 1'b1; io_d = '0;
        repeat (6) tick();
        io_d = 8'h01;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (io_q !== ((e >= 5) ? 8'h01 : 8'h00)) begin
                errors++;
                $display("FAIL basic_q edge %0d got %h exp %h", e, io_q, (e >= 5) ? 8'h01 : 8'h00);
            end
            checks++;
            if (io_rise !== ((EDGE_EN && e == 6) ? 8'h01 : 8'h00)) begin
                errors++;
                $display("FAIL basic_rise edge %0d got %h", e, io_rise);
            end
        end
        io_d = '0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL basic_fall_model edge %0d got %h exp %h", e, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_glitch();
        int highs;
        io_thresh = 4'd4; io_d = '0;
        repeat (8) tick();
        io_d = 8'h04;
        repeat (3) tick();
        io_d = '0;
        for (int e = 0; e < 10; e++) begin
            tick();
            checks++;
            if (io_q[2] !== 1'b0 || io_rise[2] !== 1'b0) begin
                errors++;
                $display("FAIL glitch3 cycle %0d got q=%b rise=%b exp 0", e, io_q[2], io_rise[2]);
            end
        end
        io_d  = 8'h04;
        highs = 0;
        repeat (4) begin
            tick();
            if (io_q[2]) highs++;
        end
        io_d = '0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (io_q[2]) highs++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL glitch4_model cycle %0d got %h exp %h", e, dut_vec, exp_vec());
            end
        end
        checks++;
        if (highs != 4) begin
            errors++;
            $display("FAIL glitch4_width got %0d exp 4", highs);
        end
    endtask

    task automatic test_thresh_zero();
        logic [CH-1:0] dsamp [$];
        io_thresh = '0; io_en = 1'b1;
        dsamp = {};
        for (int n = 1; n <= 24; n++) begin
            io_d = 8'($urandom);
            dsamp.push_back(io_d);
            tick();
            if (n >= 3) begin
                checks++;
                if (io_q !== dsamp[n-3]) begin
                    errors++;
                    $display("FAIL thresh0 edge %0d got %h exp %h", n, io_q, dsamp[n-3]);
                end
            end
        end
    endtask

    task automatic test_enable();
        logic [CH-1:0] frozen;
        io_thresh = 4'd3; io_en = 1'b1; io_d = '0;
        repeat (10) tick();
        frozen = io_q;
        io_en  = 1'b0;
        for (int e = 0; e < 10; e++) begin
            io_d = 8'($urandom);
            tick();
            checks++;
            if (io_q !== frozen || (io_rise | io_fall) !== '0) begin
                errors++;
                $display("FAIL enable_frozen cycle %0d got q=%h r=%h f=%h exp q=%h", e, io_q, io_rise, io_fall, frozen);
            end
        end
        io_d = '1;
        repeat (4) tick();
        io_en = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (io_q !== ((e >= 3) ? 8'hFF : 8'h00)) begin
                errors++;
                $display("FAIL enable_resume edge %0d got %h exp %h", e, io_q, (e >= 3) ? 8'hFF : 8'h00);
            end
        end
    endtask

    task automatic test_pend_clear();
        bit found = 0;
        io_thresh = 4'd1; io_en = 1'b1; io_ie = '0; io_clr = '1; io_d = 8'h02;
        tick();
        io_clr = '0;
        repeat (6) tick();
        io_ie = 8'h02;
        io_d  = 8'h00;
        for (int e = 0; e < 10 && !found; e++) begin
            tick();
            if (io_fall[1]) found = 1;
        end
        checks++;
        if (EDGE_EN && !found) begin
            errors++;
            $display("FAIL pend_fall_seen got 0 exp 1");
        end
        io_clr = 8'h02;
        tick();
        checks++;
        if (io_pend[1] !== EDGE_EN || io_irq !== EDGE_EN) begin
            errors++;
            $display("FAIL pend_set_wins got pend=%b irq=%b exp %b", io_pend[1], io_irq, EDGE_EN);
        end
        tick();
        checks++;
        if (io_pend[1] !== 1'b0 || io_irq !== 1'b0) begin
            errors++;
            $display("FAIL pend_cleared got pend=%b irq=%b exp 0", io_pend[1], io_irq);
        end
        io_clr = '0; io_ie = '0;
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL pend_model got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_reset_midcount();
        io_thresh = 4'd3; io_en = 1'b1; io_d = '0;
        repeat (8) tick();
        io_d = 8'h01;
        repeat (3) tick();
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL reset_mid_async got %h exp 0", dut_vec);
        end
        #1;
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (io_q !== ((e >= 5) ? 8'h01 : 8'h00) || io_irq !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_recover edge %0d got q=%h irq=%b exp q=%h", e, io_q, io_irq, (e >= 5) ? 8'h01 : 8'h00);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 5) == 0) io_d[i] = ~io_d[i];
            if ($urandom_range(0, 19) == 0) io_thresh = CW'($urandom_range(0, 6));
            io_en  = ($urandom_range(0, 9) != 0);
            io_ie  = 8'($urandom);
            io_clr = 8'($urandom) & 8'($urandom);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d got %h exp %h", n, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_glitch();
        test_thresh_zero();
        test_enable();
        test_pend_clear();
        test_reset_midcount();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
